// File: rtl/shift_add_mul_ctrl.sv
// Shift-and-add multiplier controller around a WIDTH-bit ripple adder.
// Optional one-entry start queue: define MUL_START_QUEUE_EN.
module shift_add_mul_ctrl #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_q;
  logic                 r_c;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_load;
  logic [WIDTH-1:0]     w_ld_m;
  logic [WIDTH-1:0]     w_ld_q;
  logic                 w_step;
  logic                 w_last;
  logic                 w_c;
  logic [WIDTH-1:0]     w_acc;
  logic [2*WIDTH:0]     w_shift;

`ifdef MUL_START_QUEUE_EN
  logic                 r_pend_valid;
  logic [WIDTH-1:0]     r_pend_m;
  logic [WIDTH-1:0]     r_pend_q;
  logic                 w_pend_use;
`endif

  assign done    = r_done;
  assign product = r_product;
  assign w_last  = (r_cnt == CNT_W'(1));

  // Add-or-hold then shift {C,ACC,Q} right; r_c is cleared by every
  // shift, so it supplies the zero carry when Q[0] skips the add.
  assign w_c     = r_q[0] ? add_cout : r_c;
  assign w_acc   = r_q[0] ? add_sum  : r_acc;
  assign w_shift = {w_c, w_acc, r_q} >> 1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, handshake and adder drive.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ld_m      = multiplicand;
    w_ld_q      = multiplier;
    w_step      = 1'b0;
    ready       = 1'b0;
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;
`ifdef MUL_START_QUEUE_EN
    w_pend_use  = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        add_a  = r_acc;
        add_b  = r_m;
        w_step = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
`ifdef MUL_START_QUEUE_EN
        if (r_pend_valid) begin
          w_load      = 1'b1;
          w_pend_use  = 1'b1;
          w_ld_m      = r_pend_m;
          w_ld_q      = r_pend_q;
          w_state_nxt = S_CALC;
        end else if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CALC;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand load, iteration datapath, product and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= w_step && w_last;
      if (w_load) begin
        r_m   <= w_ld_m;
        r_q   <= w_ld_q;
        r_acc <= '0;
        r_c   <= 1'b0;
        r_cnt <= CNT_W'(WIDTH);
      end else if (w_step) begin
        r_c   <= w_shift[2*WIDTH];
        r_acc <= w_shift[2*WIDTH-1:WIDTH];
        r_q   <= w_shift[WIDTH-1:0];
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) r_product <= w_shift[2*WIDTH-1:0];
      end
    end
  end

`ifdef MUL_START_QUEUE_EN
  // One-entry buffer for a start that arrives while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_m     <= '0;
      r_pend_q     <= '0;
    end else if (w_pend_use) begin
      r_pend_valid <= 1'b0;
    end else if (start && (r_state == S_CALC) && !r_pend_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_m     <= multiplicand;
      r_pend_q     <= multiplier;
    end
  end
`endif

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Bench for shift_add_mul_ctrl with a behavioural 3-bit adder.
// Busy-start case follows MUL_START_QUEUE_EN when defined.
module tb_shift_add_mul_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] multiplicand;
  logic [2:0] multiplier;
  logic       ready;
  logic       done;
  logic [5:0] product;
  logic [2:0] add_a;
  logic [2:0] add_b;
  logic       add_cin;
  logic [2:0] add_sum;
  logic       add_cout;

  int errors;
  int checks;
  int cyc;
  logic saw_cout;

  shift_add_mul_ctrl #(.WIDTH(3), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .done         (done),
    .product      (product),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout)
  );

  // Ripple adder stand-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {3'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] m;
    logic [2:0] q;
    logic [5:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Start one multiplication as soon as ready, return the product
  // and the cycle number at which done was seen.
  task automatic run_mul(input logic [2:0] m, input logic [2:0] q,
                         output logic [5:0] p, output int dcyc);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", int'(ready), 1);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = 3'($urandom);
    multiplier   = 3'($urandom);
    check("busy_ready", int'(ready), 0);
    check("drive_b", int'(add_b), int'(m));
    check("drive_a", int'(add_a), 0);
    check("drive_cin", int'(add_cin), 0);
    n = 0;
    while (!done && n < 20) begin
      if (add_cout) saw_cout = 1'b1;
      tick();
      n++;
    end
    check("latency", n, 3);
    p    = product;
    dcyc = cyc;
    tick();
    check("done_pulse", int'(done), 0);
    check("ready_back", int'(ready), 1);
  endtask

  initial begin
    vec_t vecs[6];
    logic [5:0] p;
    int dcyc;
    int prev;
    logic [2:0] rm;
    logic [2:0] rq;

    errors = 0;
    checks = 0;
    cyc    = 0;
    saw_cout = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    vecs[0] = '{3'd5, 3'd3, 6'd15};
    vecs[1] = '{3'd7, 3'd7, 6'd49};
    vecs[2] = '{3'd0, 3'd6, 6'd0};
    vecs[3] = '{3'd6, 3'd0, 6'd0};
    vecs[4] = '{3'd1, 3'd1, 6'd1};
    vecs[5] = '{3'd7, 3'd1, 6'd7};

    #12;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_product", int'(product), 0);
    check("rst_add_a", int'(add_a), 0);
    check("rst_add_b", int'(add_b), 0);
    check("rst_cin", int'(add_cin), 0);
    tick();
    rst = 1'b0;
    tick();

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      if (i == 1) saw_cout = 1'b0;
      run_mul(vecs[i].m, vecs[i].q, p, dcyc);
      check($sformatf("vec%0d_product", i), int'(p), int'(vecs[i].exp));
      if (i == 1) check("cout_seen", int'(saw_cout), 1);
    end

    // Exhaustive back-to-back sweep.
    prev = 0;
    for (int i = 0; i < 64; i++) begin
      rm = 3'(i >> 3);
      rq = 3'(i);
      run_mul(rm, rq, p, dcyc);
      check($sformatf("sweep_%0dx%0d", rm, rq), int'(p), int'(rm) * int'(rq));
      if (i > 0) check("spacing", dcyc - prev, 5);
      prev = dcyc;
    end

    // Random operands with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      rm = 3'($urandom);
      rq = 3'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      run_mul(rm, rq, p, dcyc);
      check("rand_product", int'(p), int'(rm) * int'(rq));
    end

    // Reset during the second CALC cycle.
    multiplicand = 3'd5;
    multiplier   = 3'd3;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done), 0);
    check("abort_product", int'(product), 0);
    check("abort_add_a", int'(add_a), 0);
    check("abort_add_b", int'(add_b), 0);
    check("abort_cin", int'(add_cin), 0);
    tick();
    tick();
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (done) seen++;
      end
      check("abort_no_done", seen, 0);
      check("abort_product_hold", int'(product), 0);
    end
    run_mul(3'd2, 3'd3, p, dcyc);
    check("after_abort", int'(p), 6);

    // Start pulsed while busy.
    multiplicand = 3'd5;
    multiplier   = 3'd3;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    tick();
    multiplicand = 3'd3;
    multiplier   = 3'd2;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = 3'd0;
    multiplier   = 3'd0;
    tick();
    check("busy_first_done", int'(done), 1);
    check("busy_first_prod", int'(product), 15);
`ifdef MUL_START_QUEUE_EN
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("queue_ready_low", int'(ready), 0);
      check("queue_done", int'(done), (k == 4) ? 1 : 0);
    end
    check("queue_product", int'(product), 6);
    tick();
    check("queue_ready_back", int'(ready), 1);
`else
    begin
      int seen;
      seen = 0;
      tick();
      check("ignore_ready_back", int'(ready), 1);
      for (int k = 0; k < 8; k++) begin
        tick();
        if (done) seen++;
      end
      check("ignore_no_done", seen, 0);
      check("ignore_product", int'(product), 15);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_add_mul_ctrl.md
Name: shift_add_mul_ctrl

Overview:
- Sequential shift-and-add multiplier controller; the stage wrapped around the 3-bit ripple adder.
- Drives the adder's operand and carry inputs, then consumes its sum and carry-out every iteration.
- Produces an unsigned 2*WIDTH-bit product with a start/ready/done handshake to the surrounding datapath.
- One adder pass per multiplier bit, so latency is fixed.

Parameters:
- WIDTH, 3, operand width; must match the adder width.
- CNT_W, 2, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only when ready=1
- multiplicand  input  WIDTH  operand M, latched on an accepted start
- multiplier  input  WIDTH  operand Q, latched on an accepted start
- ready  output  1  idle and able to accept start
- done  output  1  one-cycle completion pulse
- product  output  2*WIDTH  result, held until the next completion
- add_a  output  WIDTH  adder operand A (accumulator)
- add_b  output  WIDTH  adder operand B (multiplicand)
- add_cin  output  1  adder carry-in
- add_sum  input  WIDTH  adder sum
- add_cout  input  1  adder carry-out

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ready=1, done=0, product=0.
  - Internal registers M, ACC, Q, C and cnt are all 0.
  - Reset mid-operation aborts with no done pulse; product returns to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - On start=1 at the edge: M<=multiplicand, Q<=multiplier, ACC<=0, C<=0, cnt<=WIDTH, state<=CALC.
- CALC (ready=0), one edge per iteration:
  - If Q[0]=1: {C,ACC}<={add_cout,add_sum}, else {C,ACC}<={0,ACC}.
  - The add and the right shift happen in the same edge: {C,ACC,Q}<=({C',ACC',Q})>>1, with 0 shifted into C.
  - cnt<=cnt-1.
  - When cnt=1, state<=DONE.
- DONE (ready=0):
  - Entered on the edge that performs the final shift; product<={ACC,Q} and done<=1 are loaded on that same edge.
  - The next edge: done<=0, state<=IDLE.
- Latency:
  - An accepted start at edge E gives done=1 during the cycle after edge E+WIDTH.
  - done is high for exactly 1 cycle.
  - ready returns at edge E+WIDTH+1.
  - Throughput: one product every WIDTH+2 cycles.
- Adder drive (combinational from registers):
  - add_a=ACC, add_b=M, add_cin=0 in CALC.
  - add_a, add_b and add_cin are all 0 in IDLE and DONE.
- Arithmetic:
  - Unsigned only; the product never overflows 2*WIDTH bits.
  - add_cout is captured into C and shifted into the product MSB path.
- Boundaries:
  - start while ready=0 is ignored (unless the optional feature is enabled).
  - A zero operand still takes the full WIDTH iterations.
  - Operand inputs may change freely after the accepting edge.

Optional Feature:
- Macro: MUL_START_QUEUE_EN.
- Defined:
  - Adds a one-entry pending buffer (pend_valid, pend_m, pend_q).
  - start=1 while ready=0 and pend_valid=0 captures the operands and sets pend_valid.
  - From DONE, if pend_valid=1, the next edge loads the pending operands and enters CALC directly, clearing pend_valid; ready stays 0.
  - A further start while pend_valid=1 is dropped.
  - Reset clears pend_valid.
- Undefined:
  - No buffer exists; start is honoured only in IDLE.

Test Plan:
- Reset, then M=5, Q=3, start pulse at edge E -> done=1 exactly in the cycle after E+3, product=15 (6'b001111), ready=1 at E+4.
- M=7, Q=7 -> product=49, with add_cout=1 observed during at least one CALC cycle.
- M=0, Q=6, then M=6, Q=0 -> product=0 both times, each done after the full 3 iterations.
- Exhaustive sweep of all 64 operand pairs, back-to-back starts asserted as soon as ready=1 -> every product equals M*Q, done spacing is 5 cycles.
- Assert rst during the second CALC cycle of 5*3 -> done never pulses, product=0, ready=1 and adder drive all 0 during reset; a fresh 2*3 run then gives 6.
- start (M=3, Q=2) pulsed during a busy 5*3 run:
  - Macro off: ignored; only 15 is produced.
  - Macro on: done for 15, then a second done with 6 exactly 4 cycles later, ready low throughout.
